wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage pipeline: accepts completed instructions from the MEM stage and produces the register-file write port (`WB_EN`, `WB_Dest`, `WB_Data`) that the ID stage consumes. ALU results are written back one cycle after acceptance. Loads wait on a variable-latency data-memory read return, stalling the MEM stage until the data arrives or a timeout expires. A wrapping retired-instruction counter is kept for debug.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum number of WAIT cycles for a load return before it is abandoned; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  MEM stage presents an instruction.
- `in_ready`  out  1  stage can accept; `(state == IDLE)`.
- `in_wb_en`  in  1  instruction writes a register.
- `in_mem_r_en`  in  1  instruction is a load.
- `in_dest`  in  5  destination register.
- `in_alu_result`  in  32  ALU result for non-loads.
- `dmem_rvalid`  in  1  load data valid this cycle.
- `dmem_rdata`  in  32  load data.
- `WB_EN`  out  1  register-file write enable, one-cycle pulse per write.
- `WB_Dest`  out  5  write address.
- `WB_Data`  out  32  write data.
- `load_err`  out  1  one-cycle pulse when a load times out.
- `retire_cnt`  out  32  count of completed instructions.

## Operation
- FSM states:
  - IDLE: `in_ready = 1`.
  - WAIT: a load is outstanding; `in_ready = 0`.
- Accept means `in_valid && in_ready` at a posedge.
- IDLE, accept with `in_mem_r_en = 0`:
  - Register `WB_EN <= in_wb_en`, `WB_Dest <= in_dest`, `WB_Data <= in_alu_result`.
  - `retire_cnt` increments.
  - Remain in IDLE.
- IDLE, accept with `in_mem_r_en = 1`:
  - Latch `in_dest` and `in_wb_en`; clear the timeout counter.
  - Go to WAIT. `WB_EN <= 0`.
- WAIT, `dmem_rvalid = 1`:
  - `WB_EN <= latched wb_en`, `WB_Dest <= latched dest`, `WB_Data <= dmem_rdata`.
  - `retire_cnt` increments; go to IDLE.
- WAIT, `dmem_rvalid = 0`:
  - Counter increments.
  - When counter reaches `TIMEOUT`: `load_err <= 1` for one cycle, no write, no retire increment, go to IDLE.
- `dmem_rvalid` in IDLE is ignored: no write, no error.
- When nothing is written in a cycle, `WB_EN <= 0`. `WB_Dest`/`WB_Data` hold their previous values.
- A load with `in_wb_en = 0` still waits for its data and retires, but produces no write.
- Destination 0 is written like any other register; no special case.
- `retire_cnt` wraps from `0xFFFFFFFF` to 0. It is 32-bit unsigned.

## Timing
- Reset (any state, including mid-WAIT):
  - state IDLE; the outstanding load is discarded with no write and no error.
  - `WB_EN = 0`, `WB_Dest = 0`, `WB_Data = 0`, `load_err = 0`, `retire_cnt = 0`.
  - `in_ready = 1` in the cycle after reset.
- Non-load latency: accepted at edge N; `WB_EN` high during cycle N..N+1. The register file samples it on the following negedge.
- Load latency:
  - Accept at edge N; `dmem_rvalid` is sampled from edge N+1 onward.
  - Return sampled at edge M gives `WB_EN` high during M..M+1.
  - Back-to-back is allowed: `in_ready` is high again in cycle M..M+1.
- Timeout:
  - With no return, `load_err` pulses after exactly `TIMEOUT` WAIT edges, and IDLE is re-entered at the same edge.
  - If `dmem_rvalid` arrives on the same edge the counter would expire, the data wins: write, no error.
- Throughput:
  - One non-load per cycle.
  - A load occupies 1 + latency cycles; `in_ready` is low throughout WAIT.
- `in_*` are don't-care when `in_valid = 0`.
- `dmem_*` are don't-care outside WAIT.

## Test plan
- Reset, then accept ADD (dest=5, alu=0x1234, wb_en=1) -> next cycle `WB_EN=1`, `WB_Dest=5`, `WB_Data=0x1234`; `retire_cnt=1`; following cycle `WB_EN=0`.
- Load dest=7, `dmem_rvalid` high with 0xDEADBEEF 3 cycles after accept -> `in_ready` low for 3 cycles; one write of 0xDEADBEEF to r7; `retire_cnt` +1.
- Load with no return, `TIMEOUT=4` -> `load_err` pulses once after 4 WAIT cycles; no `WB_EN`; `retire_cnt` unchanged; a following non-load is accepted normally.
- `dmem_rvalid` on the expiry edge (`TIMEOUT=4`, return on the 4th WAIT edge) -> write occurs and `load_err` stays 0.
- Assert `rst` while in WAIT, then `dmem_rvalid` -> no write, all outputs 0, `in_ready=1`.
- Store with `in_wb_en=0` and `in_mem_r_en=0`, back-to-back with an ADD -> store retires without a write, ADD writes next cycle; `retire_cnt` +2; preload `retire_cnt` near `0xFFFFFFFF` to check the wrap to 0.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake, data-memory return and register-file write port.
interface wb_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_wb_en;
    logic        in_mem_r_en;
    logic [4:0]  in_dest;
    logic [31:0] in_alu_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        WB_EN;
    logic [4:0]  WB_Dest;
    logic [31:0] WB_Data;
    logic        load_err;
    logic [31:0] retire_cnt;

    modport master (
        output in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result,
               dmem_rvalid, dmem_rdata,
        input  in_ready, WB_EN, WB_Dest, WB_Data, load_err, retire_cnt
    );

    modport slave (
        input  in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result,
               dmem_rvalid, dmem_rdata,
        output in_ready, WB_EN, WB_Dest, WB_Data, load_err, retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: registers ALU results, waits on load returns with a
// bounded timeout, and keeps a wrapping retired-instruction counter.
module wb_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  bus
);
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_stage: TIMEOUT out of range 1..255");
    end

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [4:0]  ld_dest_q, ld_dest_d;
    logic        ld_wb_q, ld_wb_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q;
    logic        retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            ld_dest_q <= '0;
            ld_wb_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            dest_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            ld_dest_q <= ld_dest_d;
            ld_wb_q   <= ld_wb_d;
            wb_en_q   <= wb_en_d;
            dest_q    <= dest_d;
            data_q    <= data_d;
            err_q     <= err_d;
            if (retire) cnt_q <= cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        ld_dest_d = ld_dest_q;
        ld_wb_d   = ld_wb_q;
        wb_en_d   = 1'b0;
        dest_d    = dest_q;
        data_d    = data_q;
        err_d     = 1'b0;
        retire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_mem_r_en) begin
                        ld_dest_d = bus.in_dest;
                        ld_wb_d   = bus.in_wb_en;
                        tmo_d     = '0;
                        state_d   = WAIT;
                    end else begin
                        wb_en_d = bus.in_wb_en;
                        dest_d  = bus.in_dest;
                        data_d  = bus.in_alu_result;
                        retire  = 1'b1;
                    end
                end
            end
            WAIT: begin
                // A return on the expiry edge takes priority over the timeout.
                if (bus.dmem_rvalid) begin
                    wb_en_d = ld_wb_q;
                    dest_d  = ld_dest_q;
                    data_d  = bus.dmem_rdata;
                    retire  = 1'b1;
                    state_d = IDLE;
                end else if (tmo_q + 8'd1 == TMO) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.WB_EN      = wb_en_q;
    assign bus.WB_Dest    = dest_q;
    assign bus.WB_Data    = data_q;
    assign bus.load_err   = err_q;
    assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboarded bench for wb_stage: expected writes queued at issue, popped by a
// negedge monitor whenever WB_EN is seen.
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    always #5 clk = ~clk;

    wb_stage_if bus();

    wb_stage #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (!rst && bus.WB_EN === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got dest=%0d data=%h, required no write",
                         bus.WB_Dest, bus.WB_Data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.WB_Dest !== e.dest || bus.WB_Data !== e.data) begin
                    bad++;
                    $display("FAIL write_value got dest=%0d data=%h, required dest=%0d data=%h",
                             bus.WB_Dest, bus.WB_Data, e.dest, e.data);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic ld, input logic wb,
                         input logic [4:0] d, input logic [31:0] alu);
        bus.in_valid      = v;
        bus.in_mem_r_en   = ld;
        bus.in_wb_en      = wb;
        bus.in_dest       = d;
        bus.in_alu_result = alu;
        if (v && !ld && wb) exp_q.push_back({d, alu});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.WB_EN, bus.WB_Dest, bus.WB_Data, bus.load_err, bus.retire_cnt} !== '0 ||
            bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got en=%b dest=%0d data=%h err=%b cnt=%0d rdy=%b, required zeros rdy=1",
                     bus.WB_EN, bus.WB_Dest, bus.WB_Data, bus.load_err, bus.retire_cnt, bus.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_alu();
        drive(1, 0, 1, 5'd5, 32'h1234);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        total++;
        if (bus.WB_EN !== 1'b1 || bus.retire_cnt !== 32'd1) begin
            bad++;
            $display("FAIL alu_write got en=%b cnt=%0d required en=1 cnt=1", bus.WB_EN, bus.retire_cnt);
        end
        @(negedge clk);
        total++;
        if (bus.WB_EN !== 1'b0) begin
            bad++;
            $display("FAIL alu_pulse got en=%b required 0", bus.WB_EN);
        end
    endtask

    task automatic test_load();
        logic [31:0] c0;
        c0 = bus.retire_cnt;
        drive(1, 1, 1, 5'd7, 32'h0);
        exp_q.push_back({5'd7, 32'hDEADBEEF});
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.in_ready !== 1'b0 || bus.WB_EN !== 1'b0) begin
                bad++;
                $display("FAIL load_wait_%0d got rdy=%b en=%b required rdy=0 en=0", i, bus.in_ready, bus.WB_EN);
            end
            if (i < 2) @(negedge clk);
        end
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'h0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.WB_EN !== 1'b1 || bus.retire_cnt !== c0 + 32'd1) begin
            bad++;
            $display("FAIL load_return got rdy=%b en=%b cnt=%0d required rdy=1 en=1 cnt=%0d",
                     bus.in_ready, bus.WB_EN, bus.retire_cnt, c0 + 32'd1);
        end
        @(negedge clk);
        total++;
        if (bus.WB_EN !== 1'b0) begin
            bad++;
            $display("FAIL load_pulse got en=%b required 0", bus.WB_EN);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] c0;
        c0 = bus.retire_cnt;
        drive(1, 1, 1, 5'd8, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.load_err !== 1'b0 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL timeout_wait_%0d got err=%b rdy=%b required err=0 rdy=0", i, bus.load_err, bus.in_ready);
            end
            @(negedge clk);
        end
        total++;
        if (bus.load_err !== 1'b1 || bus.in_ready !== 1'b1 || bus.retire_cnt !== c0) begin
            bad++;
            $display("FAIL timeout_err got err=%b rdy=%b cnt=%0d required err=1 rdy=1 cnt=%0d",
                     bus.load_err, bus.in_ready, bus.retire_cnt, c0);
        end
        drive(1, 0, 1, 5'd3, 32'hA5A5_0003);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        total++;
        if (bus.load_err !== 1'b0 || bus.WB_EN !== 1'b1 || bus.retire_cnt !== c0 + 32'd1) begin
            bad++;
            $display("FAIL after_timeout got err=%b en=%b cnt=%0d required err=0 en=1 cnt=%0d",
                     bus.load_err, bus.WB_EN, bus.retire_cnt, c0 + 32'd1);
        end
        @(negedge clk);
    endtask

    task automatic test_expiry_race();
        logic [31:0] c0;
        c0 = bus.retire_cnt;
        drive(1, 1, 1, 5'd9, 32'h0);
        exp_q.push_back({5'd9, 32'hCAFEF00D});
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.load_err !== 1'b0) begin
                bad++;
                $display("FAIL race_wait_%0d got err=%b required 0", i, bus.load_err);
            end
            if (i == 3) begin
                bus.dmem_rvalid = 1'b1;
                bus.dmem_rdata  = 32'hCAFEF00D;
            end
            @(negedge clk);
        end
        bus.dmem_rvalid = 1'b0;
        total++;
        if (bus.load_err !== 1'b0 || bus.WB_EN !== 1'b1 || bus.retire_cnt !== c0 + 32'd1) begin
            bad++;
            $display("FAIL race_data_wins got err=%b en=%b cnt=%0d required err=0 en=1 cnt=%0d",
                     bus.load_err, bus.WB_EN, bus.retire_cnt, c0 + 32'd1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        drive(1, 1, 1, 5'd11, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h1111_2222;
        @(negedge clk);
        total++;
        if ({bus.WB_EN, bus.WB_Dest, bus.WB_Data, bus.load_err, bus.retire_cnt} !== '0 ||
            bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_wait got en=%b dest=%0d data=%h err=%b cnt=%0d rdy=%b, required zeros rdy=1",
                     bus.WB_EN, bus.WB_Dest, bus.WB_Data, bus.load_err, bus.retire_cnt, bus.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        total++;
        if (bus.WB_EN !== 1'b0 || bus.load_err !== 1'b0 || bus.in_ready !== 1'b1 || bus.retire_cnt !== 32'd0) begin
            bad++;
            $display("FAIL idle_rvalid_ignored got en=%b err=%b rdy=%b cnt=%0d required 0 0 1 0",
                     bus.WB_EN, bus.load_err, bus.in_ready, bus.retire_cnt);
        end
    endtask

    task automatic test_back_to_back_wrap();
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        drive(1, 0, 0, 5'd2, 32'h0);
        @(negedge clk);
        total++;
        if (bus.WB_EN !== 1'b0 || bus.retire_cnt !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL store_retire got en=%b cnt=%h required en=0 cnt=ffffffff", bus.WB_EN, bus.retire_cnt);
        end
        drive(1, 0, 1, 5'd0, 32'h55);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        total++;
        if (bus.WB_EN !== 1'b1 || bus.retire_cnt !== 32'd0) begin
            bad++;
            $display("FAIL add_wrap got en=%b cnt=%h required en=1 cnt=0", bus.WB_EN, bus.retire_cnt);
        end
        @(negedge clk);
        total++;
        if (bus.WB_EN !== 1'b0) begin
            bad++;
            $display("FAIL wrap_pulse got en=%b required 0", bus.WB_EN);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'h0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_load();
        test_timeout();
        test_expiry_race();
        test_reset_mid_wait();
        test_back_to_back_wrap();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_writes got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
